// File: rtl/i2c_apb_cmd_queue_if.sv
// APB3 bus bundle for the I2C command queue.
// The bus master drives the request; the queue slave drives the response.
interface i2c_apb_cmd_queue_if #(
    parameter int unsigned APB_AW = 32
) ();
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [APB_AW-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/i2c_apb_cmd_queue.sv
// APB3 slave that queues I2C register commands for a single-byte I2C master
// and collects read bytes into a response FIFO drained over APB.
module i2c_apb_cmd_queue #(
    parameter logic [31:0] BASE_ADDR  = 32'h43C0_0000,
    parameter int unsigned APB_AW     = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    i2c_apb_cmd_queue_if.slave      apb,
    output logic                    o_cmd_valid,
    input  logic                    i_cmd_ready,
    output logic                    o_cmd_rh_wl,
    output logic [15:0]             o_cmd_addr,
    output logic [7:0]              o_cmd_wdata,
    input  logic                    i_i2c_done,
    input  logic                    i_i2c_nack,
    input  logic [7:0]              i_i2c_rdata,
    output logic                    o_busy
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [APB_AW-1:0] Base = APB_AW'(BASE_ADDR);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
    state_e state_q, state_d;

    logic [24:0]   cmd_mem_q [FIFO_DEPTH];
    logic [PW-1:0] cmd_wr_q, cmd_rd_q;
    logic [CW-1:0] cmd_cnt_q;
    logic [7:0]    rsp_mem_q [FIFO_DEPTH];
    logic [PW-1:0] rsp_wr_q, rsp_rd_q;
    logic [CW-1:0] rsp_cnt_q;
    logic          enable_q, enable_d, discard_q, discard_d;
    logic          nack_q, nack_d, rsp_ovf_q, rsp_ovf_d, cmd_ovf_q, cmd_ovf_d;

    logic access, wr, rd, sel_cmd, sel_sts, sel_rd, sel_ctl, addr_ok;
    logic cmd_full, cmd_empty, rsp_full, rsp_empty;
    logic cmd_push, cmd_pop, rsp_push, rsp_pop, flush, start, done_wait, rsp_ev;
    logic [31:0] status;

    assign access  = apb.PSEL & apb.PENABLE;
    assign wr      = access & apb.PWRITE;
    assign rd      = access & ~apb.PWRITE;
    assign sel_cmd = apb.PADDR == Base;
    assign sel_sts = apb.PADDR == Base + APB_AW'(4);
    assign sel_rd  = apb.PADDR == Base + APB_AW'(8);
    assign sel_ctl = apb.PADDR == Base + APB_AW'(12);
    assign addr_ok = sel_cmd | sel_sts | sel_rd | sel_ctl;

    assign cmd_full  = cmd_cnt_q == CW'(FIFO_DEPTH);
    assign cmd_empty = cmd_cnt_q == '0;
    assign rsp_full  = rsp_cnt_q == CW'(FIFO_DEPTH);
    assign rsp_empty = rsp_cnt_q == '0;

    // Full is judged on the current count, so a same-cycle pop never frees a slot.
    assign cmd_push  = wr & sel_cmd & ~cmd_full;
    assign flush     = wr & sel_ctl & apb.PWDATA[1];
    assign start     = (state_q == StIdle) & enable_q & ~cmd_empty & ~flush;
    assign cmd_pop   = start;
    assign done_wait = (state_q == StWait) & i_i2c_done;
    assign rsp_pop   = rd & sel_rd & ~rsp_empty;
    assign rsp_ev    = done_wait & o_cmd_rh_wl & ~(discard_q | flush);
    assign rsp_push  = rsp_ev & (~rsp_full | rsp_pop);

    assign o_cmd_valid = state_q == StIssue;
    assign o_busy      = (state_q != StIdle) | ~cmd_empty;
    assign apb.PREADY  = 1'b1;

    assign status = {16'b0, 4'(rsp_cnt_q), 4'(cmd_cnt_q), 1'b0, cmd_ovf_q, rsp_ovf_q,
                     nack_q, o_busy, rsp_empty, cmd_full, cmd_empty};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StIssue;
            StIssue: if (i_cmd_ready) state_d = StWait;
            StWait:  if (i_i2c_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        enable_d  = (wr & sel_ctl) ? apb.PWDATA[0] : enable_q;
        // Set wins over a same-cycle write-1-to-clear.
        nack_d    = (nack_q & ~(wr & sel_sts & apb.PWDATA[4])) | (done_wait & i_i2c_nack);
        rsp_ovf_d = (rsp_ovf_q & ~(wr & sel_sts & apb.PWDATA[5])) | (rsp_ev & ~rsp_push);
        cmd_ovf_d = (cmd_ovf_q & ~(wr & sel_sts & apb.PWDATA[6])) | (wr & sel_cmd & cmd_full);
        discard_d = (discard_q | (flush & (state_q != StIdle))) & (state_d != StIdle);
    end

    always_comb begin
        apb.PRDATA  = '0;
        apb.PSLVERR = 1'b0;
        if (access) begin
            if (!addr_ok) begin
                apb.PSLVERR = 1'b1;
            end else if (sel_cmd && apb.PWRITE) begin
                apb.PSLVERR = cmd_full;
            end else if (!apb.PWRITE) begin
                if (sel_sts) apb.PRDATA = status;
                if (sel_rd && !rsp_empty) apb.PRDATA = {23'b0, 1'b1, rsp_mem_q[rsp_rd_q]};
                if (sel_ctl) apb.PRDATA = {31'b0, enable_q};
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= StIdle;
            enable_q    <= 1'b0;
            discard_q   <= 1'b0;
            nack_q      <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            cmd_ovf_q   <= 1'b0;
            o_cmd_rh_wl <= 1'b0;
            o_cmd_addr  <= '0;
            o_cmd_wdata <= '0;
        end else begin
            state_q   <= state_d;
            enable_q  <= enable_d;
            discard_q <= discard_d;
            nack_q    <= nack_d;
            rsp_ovf_q <= rsp_ovf_d;
            cmd_ovf_q <= cmd_ovf_d;
            if (start) {o_cmd_rh_wl, o_cmd_addr, o_cmd_wdata} <= cmd_mem_q[cmd_rd_q];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cmd_wr_q  <= '0;
            cmd_rd_q  <= '0;
            cmd_cnt_q <= '0;
            rsp_wr_q  <= '0;
            rsp_rd_q  <= '0;
            rsp_cnt_q <= '0;
        end else if (flush) begin
            cmd_wr_q  <= '0;
            cmd_rd_q  <= '0;
            cmd_cnt_q <= '0;
            rsp_wr_q  <= '0;
            rsp_rd_q  <= '0;
            rsp_cnt_q <= '0;
        end else begin
            if (cmd_push) cmd_wr_q <= cmd_wr_q + PW'(1);
            if (cmd_pop)  cmd_rd_q <= cmd_rd_q + PW'(1);
            cmd_cnt_q <= cmd_cnt_q + CW'(cmd_push) - CW'(cmd_pop);
            if (rsp_push) rsp_wr_q <= rsp_wr_q + PW'(1);
            if (rsp_pop)  rsp_rd_q <= rsp_rd_q + PW'(1);
            rsp_cnt_q <= rsp_cnt_q + CW'(rsp_push) - CW'(rsp_pop);
        end
    end

    always_ff @(posedge PCLK) begin
        if (cmd_push) cmd_mem_q[cmd_wr_q] <= {apb.PWDATA[31], apb.PWDATA[23:0]};
        if (rsp_push) rsp_mem_q[rsp_wr_q] <= i_i2c_rdata;
    end

    logic unused_wdata;
    assign unused_wdata = ^apb.PWDATA[30:24];
endmodule

// File: tb/tb_i2c_apb_cmd_queue.sv
// Scoreboard bench for i2c_apb_cmd_queue: stimulus queues expected APB responses
// and I2C commands; monitors pop and compare whenever the DUT presents them.
module tb_i2c_apb_cmd_queue;
    localparam logic [31:0] BA    = 32'h43C0_0000;
    localparam logic [31:0] A_CMD = BA;
    localparam logic [31:0] A_STS = BA + 32'h4;
    localparam logic [31:0] A_RD  = BA + 32'h8;
    localparam logic [31:0] A_CTL = BA + 32'hC;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        o_cmd_valid, i_cmd_ready = 1'b0, o_cmd_rh_wl;
    logic [15:0] o_cmd_addr;
    logic [7:0]  o_cmd_wdata;
    logic        i_i2c_done = 1'b0, i_i2c_nack = 1'b0;
    logic [7:0]  i_i2c_rdata = 8'h00;
    logic        o_busy;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
    } apb_exp_t;
    apb_exp_t    apb_q[$];
    logic [31:0] cmd_q[$];

    i2c_apb_cmd_queue_if #(.APB_AW(32)) apb ();

    i2c_apb_cmd_queue #(
        .BASE_ADDR (BA),
        .APB_AW    (32),
        .FIFO_DEPTH(8)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .apb        (apb),
        .o_cmd_valid(o_cmd_valid),
        .i_cmd_ready(i_cmd_ready),
        .o_cmd_rh_wl(o_cmd_rh_wl),
        .o_cmd_addr (o_cmd_addr),
        .o_cmd_wdata(o_cmd_wdata),
        .i_i2c_done (i_i2c_done),
        .i_i2c_nack (i_i2c_nack),
        .i_i2c_rdata(i_i2c_rdata),
        .o_busy     (o_busy)
    );

    always #5 PCLK = ~PCLK;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // APB response monitor
    always @(negedge PCLK) begin
        if (apb.PSEL && apb.PENABLE) begin
            if (apb_q.size() == 0) begin
                chk("apb_unexpected_access", 32'd1, 32'd0);
            end else begin
                apb_exp_t e;
                e = apb_q.pop_front();
                chk({e.name, "_prdata"}, apb.PRDATA, e.data);
                chk({e.name, "_pslverr"}, {31'b0, apb.PSLVERR}, {31'b0, e.err});
                chk({e.name, "_pready"}, {31'b0, apb.PREADY}, 32'd1);
            end
        end
    end

    // I2C command monitor: compares each accepted command
    always @(negedge PCLK) begin
        if (PRESETn && o_cmd_valid && i_cmd_ready) begin
            if (cmd_q.size() == 0) chk("cmd_unexpected", 32'd1, 32'd0);
            else chk("cmd_accept", {7'b0, o_cmd_rh_wl, o_cmd_addr, o_cmd_wdata}, cmd_q.pop_front());
        end
    end

    task automatic apb_xfer(input string name, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_data,
                            input bit exp_err);
        @(posedge PCLK); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr;
        apb.PADDR = addr; apb.PWDATA = wdata;
        apb_q.push_back('{name, exp_data, exp_err});
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int maxc);
        bit ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge PCLK);
            if (o_cmd_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_valid_rise"}, {31'b0, ok}, 32'd1);
    endtask

    task automatic i2c_accept();
        @(posedge PCLK); #1 i_cmd_ready = 1'b1;
        @(posedge PCLK); #1 i_cmd_ready = 1'b0;
    endtask

    task automatic i2c_done(input bit nack, input logic [7:0] rdata);
        i_i2c_done = 1'b1; i_i2c_nack = nack; i_i2c_rdata = rdata;
        @(posedge PCLK); #1;
        i_i2c_done = 1'b0; i_i2c_nack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0; apb.PWDATA = '0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_valid", {31'b0, o_cmd_valid}, 32'd0);
        chk("rst_busy", {31'b0, o_busy}, 32'd0);
        chk("rst_prdata", apb.PRDATA, 32'd0);
        chk("rst_addr", {16'b0, o_cmd_addr}, 32'd0);
        PRESETn = 1'b1;
        apb_xfer("rst_status", 0, A_STS, 0, 32'h0005, 0);

        // Write command, stable hold while ready is low
        apb_xfer("t1_ctrl", 1, A_CTL, 32'h1, 32'h0, 0);
        apb_xfer("t1_cmd", 1, A_CMD, 32'h0000_1234, 32'h0, 0);
        cmd_q.push_back({7'b0, 1'b0, 16'h0012, 8'h34});
        wait_valid("t1", 2);
        for (int i = 0; i < 5; i++) begin
            chk("t1_hold", {7'b0, o_cmd_valid, o_cmd_rh_wl, o_cmd_addr, o_cmd_wdata},
                {7'b0, 1'b1, 1'b0, 16'h0012, 8'h34});
            @(negedge PCLK);
        end
        i2c_accept();
        chk("t1_valid_drop", {31'b0, o_cmd_valid}, 32'd0);
        i2c_done(1'b0, 8'h00);
        chk("t1_busy", {31'b0, o_busy}, 32'd0);
        apb_xfer("t1_status", 0, A_STS, 0, 32'h0005, 0);

        // Read command and response drain
        apb_xfer("t2_cmd", 1, A_CMD, 32'h8000_5600, 32'h0, 0);
        cmd_q.push_back({7'b0, 1'b1, 16'h0056, 8'h00});
        wait_valid("t2", 4);
        i2c_accept();
        i2c_done(1'b0, 8'hA5);
        apb_xfer("t2_status", 0, A_STS, 0, 32'h1001, 0);
        apb_xfer("t2_rdata1", 0, A_RD, 0, 32'h1A5, 0);
        apb_xfer("t2_rdata2", 0, A_RD, 0, 32'h000, 0);

        // NACK sticky and W1C, then set-wins collision
        apb_xfer("t4_cmd", 1, A_CMD, 32'h0000_0101, 32'h0, 0);
        cmd_q.push_back({7'b0, 1'b0, 16'h0001, 8'h01});
        wait_valid("t4", 4);
        i2c_accept();
        i2c_done(1'b1, 8'h77);
        apb_xfer("t4_status_nack", 0, A_STS, 0, 32'h0015, 0);
        apb_xfer("t4_w1c", 1, A_STS, 32'h10, 32'h0, 0);
        apb_xfer("t4_status_clr", 0, A_STS, 0, 32'h0005, 0);
        apb_xfer("t4_cmd2", 1, A_CMD, 32'h8000_0202, 32'h0, 0);
        cmd_q.push_back({7'b0, 1'b1, 16'h0002, 8'h02});
        wait_valid("t4b", 4);
        i2c_accept();
        fork
            apb_xfer("t4_w1c_race", 1, A_STS, 32'h10, 32'h0, 0);
            begin
                @(posedge PCLK);
                @(posedge PCLK); #1;
                i_i2c_done = 1'b1; i_i2c_nack = 1'b1; i_i2c_rdata = 8'h3C;
                @(posedge PCLK); #1;
                i_i2c_done = 1'b0; i_i2c_nack = 1'b0;
            end
        join
        apb_xfer("t4_status_race", 0, A_STS, 0, 32'h1011, 0);
        apb_xfer("t4_rdata", 0, A_RD, 0, 32'h13C, 0);
        apb_xfer("t4_w1c2", 1, A_STS, 32'h10, 32'h0, 0);

        // Flush while waiting for a read response
        apb_xfer("t5_cmd", 1, A_CMD, 32'h8000_7700, 32'h0, 0);
        cmd_q.push_back({7'b0, 1'b1, 16'h0077, 8'h00});
        wait_valid("t5", 4);
        i2c_accept();
        apb_xfer("t5_flush", 1, A_CTL, 32'h3, 32'h0, 0);
        i2c_done(1'b0, 8'h5A);
        chk("t5_busy", {31'b0, o_busy}, 32'd0);
        apb_xfer("t5_status", 0, A_STS, 0, 32'h0005, 0);
        apb_xfer("t5_rdata", 0, A_RD, 0, 32'h000, 0);
        apb_xfer("t5_ctrl", 0, A_CTL, 0, 32'h1, 0);

        // Overfill command FIFO with issuing disabled
        apb_xfer("t3_ctrl", 1, A_CTL, 32'h0, 32'h0, 0);
        for (int i = 0; i < 8; i++)
            apb_xfer("t3_push", 1, A_CMD, 32'h0000_0100 * i + i, 32'h0, 0);
        apb_xfer("t3_push_ovf", 1, A_CMD, 32'h0000_FFFF, 32'h0, 1);
        apb_xfer("t3_status", 0, A_STS, 0, 32'h084E, 0);
        chk("t3_no_valid", {31'b0, o_cmd_valid}, 32'd0);
        apb_xfer("t3_flush", 1, A_CTL, 32'h2, 32'h0, 0);
        apb_xfer("t3_status_flush", 0, A_STS, 0, 32'h0045, 0);
        apb_xfer("t3_w1c", 1, A_STS, 32'h40, 32'h0, 0);
        apb_xfer("t3_status_clr", 0, A_STS, 0, 32'h0005, 0);

        // Bad addresses have no effect
        apb_xfer("t6_rd_10", 0, BA + 32'h10, 0, 32'h0, 1);
        apb_xfer("t6_wr_10", 1, BA + 32'h10, 32'hFFFF_FFFF, 32'h0, 1);
        apb_xfer("t6_rd_base", 0, 32'h5000_0004, 0, 32'h0, 1);
        apb_xfer("t6_wr_base", 1, 32'h5000_000C, 32'h1, 32'h0, 1);
        apb_xfer("t6_wr_rdata", 1, A_RD, 32'h1FF, 32'h0, 0);
        apb_xfer("t6_status", 0, A_STS, 0, 32'h0005, 0);
        apb_xfer("t6_ctrl", 0, A_CTL, 0, 32'h0, 0);

        // Asynchronous reset during ISSUE
        apb_xfer("t6_en", 1, A_CTL, 32'h1, 32'h0, 0);
        apb_xfer("t6_cmd", 1, A_CMD, 32'h0000_0A0B, 32'h0, 0);
        wait_valid("t6", 4);
        #1 PRESETn = 1'b0;
        #1;
        chk("t6_rst_valid", {31'b0, o_cmd_valid}, 32'd0);
        chk("t6_rst_busy", {31'b0, o_busy}, 32'd0);
        chk("t6_rst_addr", {16'b0, o_cmd_addr}, 32'd0);
        @(posedge PCLK); #1 PRESETn = 1'b1;
        apb_xfer("t6_rst_status", 0, A_STS, 0, 32'h0005, 0);
        apb_xfer("t6_rst_ctrl", 0, A_CTL, 0, 32'h0, 0);

        repeat (2) @(posedge PCLK);
        chk("apb_q_drained", apb_q.size(), 32'd0);
        chk("cmd_q_drained", cmd_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
